// File: rtl/memory_register_if.sv
// Access bus for memory_register: address, write data, byte mask and registered read results.
interface memory_register_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteEnable;
  logic [ADDR_WIDTH-1:0]   dirrOutput;
  logic [DATA_WIDTH-1:0]   dataInput;
  logic [DATA_WIDTH-1:0]   dataOutput;
  logic                    addrError;

  modport master (
    output write, byteEnable, dirrOutput, dataInput,
    input  dataOutput, addrError
  );

  modport slave (
    input  write, byteEnable, dirrOutput, dataInput,
    output dataOutput, addrError
  );
endinterface

// File: rtl/memory_register.sv
// Word-addressed register bank with byte-masked writes and a registered read port.
// Define MEMORY_REGISTER_BYPASS_EN to forward same-cycle write data to the read port.
module memory_register #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
) (
  input logic               clk,
  input logic               reset,
  memory_register_if.slave  bus
);
  localparam int unsigned Lanes = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  in_range;
  logic [IdxW-1:0]       idx;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;

  assign in_range = 32'(bus.dirrOutput) < DEPTH;
  assign idx      = bus.dirrOutput[IdxW-1:0];

  always_comb begin
    old_word = '0;
    if (in_range) begin
      old_word = mem_q[idx];
    end
    merged = old_word;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (bus.byteEnable[i]) begin
        merged[8*i +: 8] = bus.dataInput[8*i +: 8];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (bus.write && in_range) begin
      mem_d[idx] = merged;
    end
  end

  always_comb begin
    data_d = '0;
    err_d  = !in_range;
    if (in_range) begin
`ifdef MEMORY_REGISTER_BYPASS_EN
      data_d = bus.write ? merged : old_word;
`else
      data_d = old_word;
`endif
    end
  end

  // Reset wins over a concurrent write: the whole array is cleared on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign bus.dataOutput = data_q;
  assign bus.addrError  = err_q;
endmodule

// File: tb/tb_memory_register.sv
// Self-checking bench for memory_register: directed vector table, sweep, and randomized model check.
module tb_memory_register;
  localparam int unsigned Depth = 16;
`ifdef MEMORY_REGISTER_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_register_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  memory_register #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(Depth)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [Depth];

  typedef struct {
    logic        rst;
    logic        wr;
    logic [3:0]  be;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp_nb;
    logic [31:0] exp_byp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Applies one cycle of inputs and returns after the edge, away from it.
  task automatic drive(input logic r, input logic w, input logic [3:0] be,
                       input logic [15:0] a, input logic [31:0] d);
    reset          = r;
    bus.write      = w;
    bus.byteEnable = be;
    bus.dirrOutput = a;
    bus.dataInput  = d;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain word array, expected result computed from the access rules.
  task automatic model_step(input string name, input logic r, input logic w,
                            input logic [3:0] be, input logic [15:0] a, input logic [31:0] d);
    logic [31:0] exp_d, newv;
    logic        exp_e;
    exp_d = 32'h0;
    exp_e = 1'b0;
    if (r) begin
      for (int i = 0; i < Depth; i++) model[i] = 32'h0;
    end else if (int'(a) >= Depth) begin
      exp_e = 1'b1;
    end else begin
      newv = model[a];
      for (int b = 0; b < 4; b++) if (be[b]) newv[8*b +: 8] = d[8*b +: 8];
      exp_d = (Byp && w) ? newv : model[a];
      if (w) model[a] = newv;
    end
    drive(r, w, be, a, d);
    check({name, "_data"}, bus.dataOutput, exp_d);
    check({name, "_err"}, {31'h0, bus.addrError}, {31'h0, exp_e});
  endtask

  initial begin
    logic [31:0] exp;
    vecs[0]  = '{1, 0, 4'h0, 16'd5,     32'h0,        32'h0,        32'h0,        0};
    vecs[1]  = '{1, 0, 4'h0, 16'd5,     32'h0,        32'h0,        32'h0,        0};
    vecs[2]  = '{0, 0, 4'h0, 16'd5,     32'h0,        32'h0,        32'h0,        0};
    vecs[3]  = '{0, 1, 4'hF, 16'd4,     32'hACEDCAFE, 32'h0,        32'hACEDCAFE, 0};
    vecs[4]  = '{0, 0, 4'h0, 16'd4,     32'h0,        32'hACEDCAFE, 32'hACEDCAFE, 0};
    vecs[5]  = '{0, 1, 4'h1, 16'd4,     32'hDEADBEEF, 32'hACEDCAFE, 32'hACEDCAEF, 0};
    vecs[6]  = '{0, 0, 4'h0, 16'd4,     32'h0,        32'hACEDCAEF, 32'hACEDCAEF, 0};
    vecs[7]  = '{0, 1, 4'hF, 16'd3,     32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0};
    vecs[8]  = '{0, 0, 4'h0, 16'd3,     32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[9]  = '{0, 1, 4'h0, 16'd3,     32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[10] = '{0, 1, 4'hF, 16'd16,    32'h12345678, 32'h0,        32'h0,        1};
    vecs[11] = '{0, 0, 4'h0, 16'hFFFF,  32'h0,        32'h0,        32'h0,        1};
    vecs[12] = '{0, 0, 4'h0, 16'd4,     32'h0,        32'hACEDCAEF, 32'hACEDCAEF, 0};
    vecs[13] = '{0, 1, 4'hC, 16'd15,    32'hA5A5_0000, 32'h0,       32'hA5A50000, 0};
    vecs[14] = '{1, 1, 4'hF, 16'd4,     32'h11111111, 32'h0,        32'h0,        0};
    vecs[15] = '{0, 0, 4'h0, 16'd4,     32'h0,        32'h0,        32'h0,        0};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].be, vecs[i].a, vecs[i].d);
      exp = Byp ? vecs[i].exp_byp : vecs[i].exp_nb;
      check($sformatf("vec%0d_data", i), bus.dataOutput, exp);
      check($sformatf("vec%0d_err", i), {31'h0, bus.addrError}, {31'h0, vecs[i].exp_err});
    end

    // Fill every word, hit the first out-of-range address, then sweep for corruption.
    model_step("sweep_rst", 1, 0, 4'h0, 16'd0, 32'h0);
    for (int i = 0; i < Depth; i++) begin
      model_step($sformatf("fill%0d", i), 0, 1, 4'hF, 16'(i), 32'hC0DE_0000 | 32'(i * 17));
    end
    model_step("oor16", 0, 1, 4'hF, 16'd16, 32'h12345678);
    for (int i = 0; i < Depth; i++) begin
      model_step($sformatf("sweep%0d", i), 0, 0, 4'h0, 16'(i), 32'h0);
    end

    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19));
      model_step($sformatf("rnd%0d", n), ($urandom_range(0, 40) == 0), 1'($urandom),
                 4'($urandom), a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
